// File: rtl/port_output_gate.sv
// Purpose: per-port frame-aware output gating; enable sampled at frame start, runaway frames truncated.
// Latency: 1 cycle, every output registered (input cycle N appears at outputs in cycle N+1).
// Backpressure: none; the stage accepts one symbol per port per cycle and never stalls upstream.
module port_output_gate #(
   parameter int NUM_PORTS     = 16,
   parameter int MAX_FRAME_LEN = 64
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NUM_PORTS-1:0] data_enable,
   input  logic [NUM_PORTS-1:0] din,
   input  logic [NUM_PORTS-1:0] valid_n,
   input  logic [NUM_PORTS-1:0] frame_n,
   output logic [NUM_PORTS-1:0] dout,
   output logic [NUM_PORTS-1:0] valido_n,
   output logic [NUM_PORTS-1:0] frameo_n,
   output logic [NUM_PORTS-1:0] trunc_err,
   output logic [NUM_PORTS-1:0] drop_pulse
);

   // Counter width is derived from the frame limit; a limit of 0 still needs one bit.
   localparam int CNT_W_RAW = $clog2(MAX_FRAME_LEN + 1);
   localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
   localparam logic [CNT_W:0] MAX_LEN = (CNT_W+1)'(MAX_FRAME_LEN);
   localparam bit TRUNC_ON = (MAX_FRAME_LEN != 0);

   // SYNC: waiting for a frame gap after reset; BLOCKED: discarding the rest of a frame.
   typedef enum logic [1:0] {
      SYNC    = 2'd0,
      IDLE    = 2'd1,
      ACTIVE  = 2'd2,
      BLOCKED = 2'd3
   } state_t;

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
      state_t           state, state_nxt;
      logic [CNT_W-1:0] count, count_nxt;
      logic             dout_nxt, valido_n_nxt, frameo_n_nxt, trunc_nxt, drop_nxt;
      logic             dout_q, valido_n_q, frameo_n_q, trunc_q, drop_q;

      // Next-state and next-output decode; idle outputs unless a frame is being forwarded.
      always_comb begin
         state_nxt    = state;
         count_nxt    = count;
         dout_nxt     = 1'b0;
         valido_n_nxt = 1'b1;
         frameo_n_nxt = 1'b1;
         trunc_nxt    = 1'b0;
         drop_nxt     = 1'b0;
         case (state)
            SYNC: begin
               if (frame_n[i]) state_nxt = IDLE;
            end
            IDLE: begin
               if (!frame_n[i]) begin
                  if (data_enable[i]) begin
                     dout_nxt     = din[i];
                     valido_n_nxt = valid_n[i];
                     frameo_n_nxt = 1'b0;
                     count_nxt    = CNT_W'(1);
                     state_nxt    = ACTIVE;
                     // A one-cycle limit makes the start cycle itself the forced end.
                     if (TRUNC_ON && MAX_FRAME_LEN == 1) begin
                        frameo_n_nxt = 1'b1;
                        trunc_nxt    = 1'b1;
                        count_nxt    = '0;
                        state_nxt    = BLOCKED;
                     end
                  end else begin
                     drop_nxt  = 1'b1;
                     state_nxt = BLOCKED;
                  end
               end
            end
            ACTIVE: begin
               dout_nxt     = din[i];
               valido_n_nxt = valid_n[i];
               frameo_n_nxt = frame_n[i];
               if (frame_n[i]) begin
                  count_nxt = '0;
                  state_nxt = IDLE;
               end else if (TRUNC_ON && (({1'b0, count} + (CNT_W+1)'(1)) == MAX_LEN)) begin
                  frameo_n_nxt = 1'b1;
                  trunc_nxt    = 1'b1;
                  count_nxt    = '0;
                  state_nxt    = BLOCKED;
               end else if (count != '1) begin
                  count_nxt = count + CNT_W'(1);
               end
            end
            BLOCKED: begin
               if (frame_n[i]) state_nxt = IDLE;
            end
            default: state_nxt = SYNC;
         endcase
      end

      // State, counter and output registers; reset forces idle outputs immediately.
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            state      <= SYNC;
            count      <= '0;
            dout_q     <= 1'b0;
            valido_n_q <= 1'b1;
            frameo_n_q <= 1'b1;
            trunc_q    <= 1'b0;
            drop_q     <= 1'b0;
         end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            dout_q     <= dout_nxt;
            valido_n_q <= valido_n_nxt;
            frameo_n_q <= frameo_n_nxt;
            trunc_q    <= trunc_nxt;
            drop_q     <= drop_nxt;
         end
      end

      assign dout[i]       = dout_q;
      assign valido_n[i]   = valido_n_q;
      assign frameo_n[i]   = frameo_n_q;
      assign trunc_err[i]  = trunc_q;
      assign drop_pulse[i] = drop_q;
   end

endmodule

// File: tb/tb_port_output_gate.sv
// Purpose: directed self-checking bench for port_output_gate with a 16-cycle frame limit.
// Latency: expects every input cycle to show at the outputs one clock later.
// Backpressure: none exercised; the DUT has no stall path.
module tb_port_output_gate;
   localparam int NP  = 16;
   localparam int MFL = 16;

   logic          clock = 1'b0;
   logic          reset;
   logic [NP-1:0] data_enable, din, valid_n, frame_n;
   logic [NP-1:0] dout, valido_n, frameo_n, trunc_err, drop_pulse;
   logic [NP-1:0] e_dout, e_valn, e_frmn, e_trunc, e_drop;

   int n_chk  = 0;
   int n_pass = 0;

   bit p1 [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

   port_output_gate #(.NUM_PORTS(NP), .MAX_FRAME_LEN(MFL)) dut (
      .clock       (clock),
      .reset       (reset),
      .data_enable (data_enable),
      .din         (din),
      .valid_n     (valid_n),
      .frame_n     (frame_n),
      .dout        (dout),
      .valido_n    (valido_n),
      .frameo_n    (frameo_n),
      .trunc_err   (trunc_err),
      .drop_pulse  (drop_pulse)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [NP-1:0] obs, input logic [NP-1:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic chk_out(input string tag, input logic [NP-1:0] x_dout, input logic [NP-1:0] x_valn,
                          input logic [NP-1:0] x_frmn, input logic [NP-1:0] x_trunc,
                          input logic [NP-1:0] x_drop);
      chk({tag, ".dout"},       dout,       x_dout);
      chk({tag, ".valido_n"},   valido_n,   x_valn);
      chk({tag, ".frameo_n"},   frameo_n,   x_frmn);
      chk({tag, ".trunc_err"},  trunc_err,  x_trunc);
      chk({tag, ".drop_pulse"}, drop_pulse, x_drop);
   endtask

   task automatic chk_idle(input string tag);
      chk_out(tag, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000);
   endtask

   task automatic drive_idle();
      data_enable = '0;
      din         = '0;
      valid_n     = '1;
      frame_n     = '1;
   endtask

   initial begin
      // Reset with all frame markers high; SYNC -> IDLE on the first free edge.
      reset = 1'b1;
      drive_idle();
      #1;
      chk_idle("reset");
      tick();
      tick();
      reset = 1'b0;
      tick();
      chk_idle("post_reset");

      // Port 3: enabled 8-cycle frame forwarded verbatim one cycle later.
      for (int k = 0; k < 8; k++) begin
         drive_idle();
         data_enable[3] = 1'b1;
         din[3]         = p1[k];
         valid_n[3]     = 1'b0;
         frame_n[3]     = (k == 7);
         tick();
         chk_out($sformatf("t1.c%0d", k), 16'(p1[k]) << 3, 16'hFFF7,
                 (k == 7) ? 16'hFFFF : 16'hFFF7, 16'h0000, 16'h0000);
      end
      drive_idle();
      tick();
      chk_idle("t1.after");

      // Port 5: disabled at start -> whole frame dropped, one drop pulse.
      for (int k = 0; k < 6; k++) begin
         drive_idle();
         din[5]     = 1'b1;
         valid_n[5] = 1'b0;
         frame_n[5] = (k == 5);
         tick();
         chk_out($sformatf("t2.c%0d", k), 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000,
                 (k == 0) ? 16'h0020 : 16'h0000);
      end
      // Next frame on port 5 with enable passes normally.
      for (int k = 0; k < 3; k++) begin
         drive_idle();
         data_enable[5] = 1'b1;
         din[5]         = (k != 2);
         valid_n[5]     = 1'b0;
         frame_n[5]     = (k == 2);
         tick();
         chk_out($sformatf("t2b.c%0d", k), (k != 2) ? 16'h0020 : 16'h0000, 16'hFFDF,
                 (k == 2) ? 16'hFFFF : 16'hFFDF, 16'h0000, 16'h0000);
      end

      // Port 0: enable drops at cycle 3 of a 10-cycle frame; valid gap at cycle 5.
      for (int k = 0; k < 10; k++) begin
         drive_idle();
         data_enable[0] = (k < 2);
         din[0]         = (k % 3 == 0);
         valid_n[0]     = (k == 4);
         frame_n[0]     = (k == 9);
         tick();
         chk_out($sformatf("t3.c%0d", k), (k % 3 == 0) ? 16'h0001 : 16'h0000,
                 (k == 4) ? 16'hFFFF : 16'hFFFE,
                 (k == 9) ? 16'hFFFF : 16'hFFFE, 16'h0000, 16'h0000);
      end

      // Port 7: frame_n held low for 40 cycles -> truncated at cycle 16, then idle.
      for (int k = 0; k < 40; k++) begin
         drive_idle();
         data_enable[7] = 1'b1;
         din[7]         = 1'(k % 2);
         valid_n[7]     = 1'b0;
         frame_n[7]     = 1'b0;
         tick();
         if (k < 16)
            chk_out($sformatf("t4.c%0d", k), (k % 2 == 1) ? 16'h0080 : 16'h0000, 16'hFF7F,
                    (k == 15) ? 16'hFFFF : 16'hFF7F, (k == 15) ? 16'h0080 : 16'h0000, 16'h0000);
         else
            chk_idle($sformatf("t4.c%0d", k));
      end
      drive_idle();
      tick();
      chk_idle("t4.end");
      // 16-cycle frame ending naturally on the limit cycle: no truncation.
      for (int k = 0; k < 16; k++) begin
         drive_idle();
         data_enable[7] = 1'b1;
         din[7]         = 1'b1;
         valid_n[7]     = 1'b0;
         frame_n[7]     = (k == 15);
         tick();
         chk_out($sformatf("t4b.c%0d", k), 16'h0080, 16'hFF7F,
                 (k == 15) ? 16'hFFFF : 16'hFF7F, 16'h0000, 16'h0000);
      end
      drive_idle();
      tick();
      chk_idle("t4b.after");

      // Port 2: reset asserted during cycle 4 of a 12-cycle frame.
      for (int k = 0; k < 3; k++) begin
         drive_idle();
         data_enable[2] = 1'b1;
         din[2]         = 1'b1;
         valid_n[2]     = 1'b0;
         frame_n[2]     = 1'b0;
         tick();
         chk_out($sformatf("t5.c%0d", k), 16'h0004, 16'hFFFB, 16'hFFFB, 16'h0000, 16'h0000);
      end
      #2;
      reset = 1'b1;
      #1;
      chk_idle("t5.rst_async");
      @(posedge clock);
      #1;
      reset = 1'b0;
      chk_idle("t5.rst_edge");
      for (int k = 4; k < 12; k++) begin
         drive_idle();
         data_enable[2] = 1'b1;
         din[2]         = 1'b1;
         valid_n[2]     = 1'b0;
         frame_n[2]     = (k == 11);
         tick();
         chk_idle($sformatf("t5.c%0d", k));
      end
      for (int k = 0; k < 3; k++) begin
         drive_idle();
         data_enable[2] = 1'b1;
         din[2]         = (k == 1);
         valid_n[2]     = 1'b0;
         frame_n[2]     = (k == 2);
         tick();
         chk_out($sformatf("t5b.c%0d", k), (k == 1) ? 16'h0004 : 16'h0000, 16'hFFFB,
                 (k == 2) ? 16'hFFFF : 16'hFFFB, 16'h0000, 16'h0000);
      end
      drive_idle();
      tick();
      chk_idle("t5b.after");

      // All ports: port i holds frame_n low for i+1 cycles; even ports enabled at start.
      for (int k = 0; k < 18; k++) begin
         drive_idle();
         data_enable = (k == 0) ? 16'h5555 : 16'hAAAA;
         for (int i = 0; i < NP; i++) begin
            if (k <= i + 1) begin
               din[i]     = 1'((k + i) % 2);
               valid_n[i] = 1'b0;
               frame_n[i] = (k == i + 1);
            end
         end
         tick();
         e_dout  = 16'h0000;
         e_valn  = 16'hFFFF;
         e_frmn  = 16'hFFFF;
         e_trunc = 16'h0000;
         e_drop  = 16'h0000;
         for (int i = 0; i < NP; i++) begin
            if (i % 2 == 0 && k <= i + 1) begin
               e_dout[i] = 1'((k + i) % 2);
               e_valn[i] = 1'b0;
               e_frmn[i] = (k == i + 1);
            end
            if (i % 2 == 1 && k == 0) e_drop[i] = 1'b1;
         end
         chk_out($sformatf("t6.c%0d", k), e_dout, e_valn, e_frmn, e_trunc, e_drop);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
